// File: rtl/reaction_timer_ctrl_if.sv
// Controller-side bundle for the reaction-timer sequencer: button/tick/LFSR/counter
// inputs plus the LED, counter-control and display outputs.
interface reaction_timer_ctrl_if #(
  parameter int unsigned DIGITS = 6
);
  localparam int unsigned W = 4 * DIGITS;

  logic         tick;
  logic         start;
  logic         stop;
  logic [12:0]  lfsr_val;
  logic [W-1:0] cnt_bcd;
  logic         cnt_en;
  logic         cnt_clr;
  logic         go_led;
  logic         fault_led;
  logic         new_hs;
  logic [W-1:0] disp_bcd;
  logic [W-1:0] hs_bcd;
  logic [2:0]   state;

  modport master (
    output tick, start, stop, lfsr_val, cnt_bcd,
    input  cnt_en, cnt_clr, go_led, fault_led, new_hs, disp_bcd, hs_bcd, state
  );

  modport slave (
    input  tick, start, stop, lfsr_val, cnt_bcd,
    output cnt_en, cnt_clr, go_led, fault_led, new_hs, disp_bcd, hs_bcd, state
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game sequencer: random arm delay, GO stimulus, reaction capture,
// best-time tracking and 7-seg display source selection.
module reaction_timer_ctrl #(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned DLY_W     = 12,
  parameter int unsigned MIN_DELAY = 1000
) (
  input  logic                 clk,
  input  logic                 Reset,
  reaction_timer_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = DLY_W + 1;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    TIMING = 3'd2,
    RESULT = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  dly_q, dly_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   hs_q, hs_d;
  logic           new_hs_q, new_hs_d;
  logic           cnt_en_q, go_led_q, fault_led_q, cnt_clr_q;
  logic           load;
  logic [CW-1:0]  dly_load;
  logic           lfsr_unused;

  // MIN_DELAY <= 2**DLY_W guarantees the sum fits in DLY_W+1 bits
  assign dly_load    = CW'(MIN_DELAY) + CW'(bus.lfsr_val[DLY_W-1:0]);
  assign lfsr_unused = ^bus.lfsr_val;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      res_q       <= '0;
      hs_q        <= ALL9;
      new_hs_q    <= 1'b0;
      cnt_en_q    <= 1'b0;
      go_led_q    <= 1'b0;
      fault_led_q <= 1'b0;
      cnt_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      res_q       <= res_d;
      hs_q        <= hs_d;
      new_hs_q    <= new_hs_d;
      cnt_en_q    <= (state_d == TIMING);
      go_led_q    <= (state_d == TIMING);
      fault_led_q <= (state_d == FAULT);
      cnt_clr_q   <= load;
    end
  end

  // Next-state and datapath updates; stop has priority only while armed or timing
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    res_d    = res_q;
    hs_d     = hs_q;
    new_hs_d = new_hs_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          load    = 1'b1;
        end
      end
      ARM: begin
        if (bus.stop) begin
          state_d = FAULT;
        end else if (bus.tick) begin
          if (dly_q == CW'(1)) state_d = TIMING;
          dly_d = dly_q - CW'(1);
        end
      end
      TIMING: begin
        // Timeout captures the live value, which is all-9s by definition
        if (bus.stop || (bus.cnt_bcd == ALL9)) begin
          state_d = RESULT;
          res_d   = bus.cnt_bcd;
        end
      end
      RESULT: begin
        if (res_q < hs_q) begin
          hs_d     = res_q;
          new_hs_d = 1'b1;
        end
        if (bus.start) begin
          state_d = ARM;
          load    = 1'b1;
        end
      end
      FAULT: begin
        if (bus.start) begin
          state_d = ARM;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) dly_d = dly_load;
    if (state_d != RESULT) new_hs_d = 1'b0;
  end

  // Display source follows the current state
  always_comb begin
    bus.disp_bcd = hs_q;
    case (state_q)
      ARM:     bus.disp_bcd = '0;
      TIMING:  bus.disp_bcd = bus.cnt_bcd;
      RESULT:  bus.disp_bcd = res_q;
      default: bus.disp_bcd = hs_q;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.go_led    = go_led_q;
  assign bus.fault_led = fault_led_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.new_hs    = new_hs_q;
  assign bus.hs_bcd    = hs_q;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl: directed scenarios plus randomized rounds
// compared against a decimal-arithmetic model of delay length and best time.
module tb_reaction_timer_ctrl;
  localparam int unsigned DIGITS    = 6;
  localparam int unsigned DLY_W     = 2;
  localparam int unsigned MIN_DELAY = 2;
  localparam int unsigned W         = 4 * DIGITS;
  localparam logic [W-1:0] ALL9     = 24'h999999;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   tcnt   = 0;

  logic [W-1:0] best_bcd;
  int           best_int;

  reaction_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  reaction_timer_ctrl #(
    .DIGITS   (DIGITS),
    .DLY_W    (DLY_W),
    .MIN_DELAY(MIN_DELAY)
  ) dut (
    .clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 ms strobe stand-in: one clk wide, every 4th clk, changed just after the rising edge
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt     = (tcnt + 1) % 4;
      bus.tick = (tcnt == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input int ndig);
    logic [W-1:0] b = '0;
    for (int i = 0; i < ndig; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  function automatic int exp_delay(input logic [12:0] lv);
    return int'(MIN_DELAY) + int'(lv % 13'(1 << DLY_W));
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press_start(input logic [12:0] lv);
    bus.cnt_bcd  = '0;
    bus.lfsr_val = lv;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  // Stay in ARM counting consumed ticks; optionally press stop with the n-th tick
  task automatic run_arm(input int stop_at, output int ticks, output int clr_hi,
                         output int en_hi, output bit ok);
    ticks = 0; clr_hi = 0; en_hi = 0; ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.state != 3'd1) begin
        ok = 1'b1;
        break;
      end
      if (bus.cnt_clr) clr_hi++;
      if (bus.cnt_en) en_hi++;
      if (bus.tick) begin
        ticks++;
        if (ticks == stop_at) bus.stop = 1'b1;
      end
      step();
      bus.stop = 1'b0;
    end
  endtask

  task automatic model_result(input logic [W-1:0] v, output bit is_new);
    is_new = bcd2int(v) < best_int;
    if (is_new) begin
      best_int = bcd2int(v);
      best_bcd = v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.lfsr_val = '0; bus.cnt_bcd = '0;
    best_bcd = ALL9; best_int = bcd2int(ALL9);
    repeat (3) step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.hs_bcd !== ALL9) begin errors++; $display("FAIL reset_hs: got %h expected %h", bus.hs_bcd, ALL9); end
    checks++; if ({bus.cnt_en, bus.cnt_clr, bus.go_led, bus.fault_led, bus.new_hs} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.cnt_en, bus.cnt_clr, bus.go_led, bus.fault_led, bus.new_hs});
    end
    rst_n = 1'b1;
    step();
    checks++; if (bus.disp_bcd !== ALL9) begin errors++; $display("FAIL idle_disp: got %h expected %h", bus.disp_bcd, ALL9); end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_stop_ignored: got %0d expected 0", bus.state); end
  endtask

  task automatic test_arm_delay();
    int ticks, clr, en; bit ok;
    press_start(13'h0003);
    checks++; if (bus.state !== 3'd1 || bus.cnt_clr !== 1'b1 || bus.disp_bcd !== '0) begin
      errors++; $display("FAIL arm_entry: state=%0d clr=%b disp=%h expected 1/1/0", bus.state, bus.cnt_clr, bus.disp_bcd);
    end
    run_arm(0, ticks, clr, en, ok);
    checks++; if (!ok || ticks != exp_delay(13'h0003)) begin
      errors++; $display("FAIL arm_ticks: got %0d (left=%0b) expected %0d", ticks, ok, exp_delay(13'h0003));
    end
    checks++; if (clr != 1) begin errors++; $display("FAIL arm_clr_pulse: got %0d cycles expected 1", clr); end
    checks++; if (bus.state !== 3'd2 || bus.go_led !== 1'b1 || bus.cnt_en !== 1'b1) begin
      errors++; $display("FAIL timing_entry: state=%0d go=%b en=%b expected 2/1/1", bus.state, bus.go_led, bus.cnt_en);
    end
  endtask

  task automatic test_first_result();
    bit is_new;
    bus.cnt_bcd = 24'h000123;
    #1;
    checks++; if (bus.disp_bcd !== 24'h000123) begin errors++; $display("FAIL live_disp: got %h expected 000123", bus.disp_bcd); end
    step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.disp_bcd !== 24'h000123 || bus.go_led !== 1'b0 || bus.cnt_en !== 1'b0) begin
      errors++; $display("FAIL result_entry: state=%0d disp=%h go=%b en=%b expected 3/000123/0/0", bus.state, bus.disp_bcd, bus.go_led, bus.cnt_en);
    end
    checks++; if (bus.hs_bcd !== ALL9 || bus.new_hs !== 1'b0) begin
      errors++; $display("FAIL result_hs_early: hs=%h new=%b expected %h/0", bus.hs_bcd, bus.new_hs, ALL9);
    end
    model_result(24'h000123, is_new);
    step();
    checks++; if (bus.hs_bcd !== best_bcd || bus.new_hs !== is_new) begin
      errors++; $display("FAIL first_best: hs=%h new=%b expected %h/%b", bus.hs_bcd, bus.new_hs, best_bcd, is_new);
    end
    step();
    checks++; if (bus.new_hs !== 1'b1) begin errors++; $display("FAIL new_hs_hold: got %b expected 1", bus.new_hs); end
  endtask

  task automatic round_checked(input logic [12:0] lv, input logic [W-1:0] v, input int extra);
    int ticks, clr, en; bit ok, is_new;
    press_start(lv);
    checks++; if (bus.state !== 3'd1 || bus.new_hs !== 1'b0 || bus.cnt_clr !== 1'b1) begin
      errors++; $display("FAIL round_arm: state=%0d new=%b clr=%b expected 1/0/1", bus.state, bus.new_hs, bus.cnt_clr);
    end
    run_arm(0, ticks, clr, en, ok);
    checks++; if (!ok || ticks != exp_delay(lv) || bus.state !== 3'd2) begin
      errors++; $display("FAIL round_delay: ticks=%0d state=%0d expected %0d/2 (lfsr=%h)", ticks, bus.state, exp_delay(lv), lv);
    end
    repeat (extra) step();
    bus.cnt_bcd = v; bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.disp_bcd !== v) begin
      errors++; $display("FAIL round_capture: state=%0d disp=%h expected 3/%h", bus.state, bus.disp_bcd, v);
    end
    model_result(v, is_new);
    step();
    checks++; if (bus.hs_bcd !== best_bcd || bus.new_hs !== is_new) begin
      errors++; $display("FAIL round_best: hs=%h new=%b expected %h/%b", bus.hs_bcd, bus.new_hs, best_bcd, is_new);
    end
  endtask

  task automatic fault_round(input logic [12:0] lv, input int k);
    int ticks, clr, en; bit ok;
    press_start(lv);
    run_arm(k, ticks, clr, en, ok);
    checks++; if (!ok || ticks != k || bus.state !== 3'd4 || bus.fault_led !== 1'b1) begin
      errors++; $display("FAIL false_start: ticks=%0d state=%0d fault=%b expected %0d/4/1", ticks, bus.state, bus.fault_led, k);
    end
    checks++; if (en != 0 || bus.cnt_en !== 1'b0 || bus.go_led !== 1'b0) begin
      errors++; $display("FAIL fault_no_enable: en_cycles=%0d en=%b go=%b expected 0/0/0", en, bus.cnt_en, bus.go_led);
    end
    checks++; if (bus.disp_bcd !== best_bcd || bus.hs_bcd !== best_bcd) begin
      errors++; $display("FAIL fault_disp: disp=%h hs=%h expected %h", bus.disp_bcd, bus.hs_bcd, best_bcd);
    end
  endtask

  task automatic test_rounds();
    logic [W-1:0] vals [2] = '{24'h000200, 24'h000050};
    for (int i = 0; i < 2; i++) round_checked(13'($urandom), vals[i], i);
  endtask

  task automatic test_false_start();
    int ticks, clr, en; bit ok;
    fault_round(13'h0003, 2);
    press_start(13'h0000);
    checks++; if (bus.state !== 3'd1 || bus.fault_led !== 1'b0 || bus.cnt_clr !== 1'b1) begin
      errors++; $display("FAIL fault_restart: state=%0d fault=%b clr=%b expected 1/0/1", bus.state, bus.fault_led, bus.cnt_clr);
    end
    step();
    checks++; if (bus.cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_one_cycle: got %b expected 0", bus.cnt_clr); end
    run_arm(0, ticks, clr, en, ok);
    checks++; if (!ok || bus.state !== 3'd2) begin errors++; $display("FAIL fault_to_timing: state=%0d expected 2", bus.state); end
  endtask

  task automatic test_simultaneous();
    int ticks, clr, en; bit ok;
    bus.cnt_bcd = 24'h000777; bus.start = 1'b1; bus.stop = 1'b1; step();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.state !== 3'd3 || bus.disp_bcd !== 24'h000777) begin
      errors++; $display("FAIL timing_both: state=%0d disp=%h expected 3/000777", bus.state, bus.disp_bcd);
    end
    step();
    checks++; if (bus.hs_bcd !== best_bcd || bus.new_hs !== 1'b0) begin
      errors++; $display("FAIL slow_keeps_best: hs=%h new=%b expected %h/0", bus.hs_bcd, bus.new_hs, best_bcd);
    end
    bus.lfsr_val = 13'h0001; bus.start = 1'b1; bus.stop = 1'b1; step();
    bus.start = 1'b0; bus.stop = 1'b0; bus.cnt_bcd = '0;
    checks++; if (bus.state !== 3'd1 || bus.cnt_clr !== 1'b1) begin
      errors++; $display("FAIL result_both: state=%0d clr=%b expected 1/1", bus.state, bus.cnt_clr);
    end
    run_arm(0, ticks, clr, en, ok);
    checks++; if (!ok || ticks != exp_delay(13'h0001)) begin
      errors++; $display("FAIL result_both_delay: got %0d expected %0d", ticks, exp_delay(13'h0001));
    end
  endtask

  task automatic test_timeout();
    bus.cnt_bcd = ALL9; step();
    checks++; if (bus.state !== 3'd3 || bus.disp_bcd !== ALL9 || bus.cnt_en !== 1'b0) begin
      errors++; $display("FAIL timeout: state=%0d disp=%h en=%b expected 3/%h/0", bus.state, bus.disp_bcd, bus.cnt_en, ALL9);
    end
    step();
    checks++; if (bus.hs_bcd !== best_bcd || bus.new_hs !== 1'b0) begin
      errors++; $display("FAIL timeout_best: hs=%h new=%b expected %h/0", bus.hs_bcd, bus.new_hs, best_bcd);
    end
  endtask

  task automatic test_random();
    logic [12:0] lv;
    for (int r = 0; r < 24; r++) begin
      lv = 13'($urandom);
      if ($urandom_range(0, 3) == 0) fault_round(lv, $urandom_range(1, exp_delay(lv)));
      else round_checked(lv, rand_bcd(($urandom_range(0, 1) == 1) ? 3 : 6), $urandom_range(0, 5));
    end
  endtask

  task automatic test_async_reset();
    int ticks, clr, en; bit ok;
    press_start(13'h0002);
    run_arm(0, ticks, clr, en, ok);
    bus.cnt_bcd = 24'h000042;
    #3 rst_n = 1'b0;
    #1;
    best_bcd = ALL9; best_int = bcd2int(ALL9);
    checks++; if (!ok || bus.state !== 3'd0 || bus.hs_bcd !== best_bcd || bus.go_led !== 1'b0 || bus.cnt_en !== 1'b0) begin
      errors++; $display("FAIL async_reset: state=%0d hs=%h go=%b en=%b expected 0/%h/0/0", bus.state, bus.hs_bcd, bus.go_led, bus.cnt_en, best_bcd);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.state !== 3'd0 || bus.disp_bcd !== ALL9) begin
      errors++; $display("FAIL post_reset_idle: state=%0d disp=%h expected 0/%h", bus.state, bus.disp_bcd, ALL9);
    end
  endtask

  initial begin
    test_reset();
    test_arm_delay();
    test_first_result();
    test_rounds();
    test_false_start();
    test_simultaneous();
    test_timeout();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
